// File: rtl/pll_reset_sequencer.sv
// Purpose: turns the PLL lock indication into a clean, debounced core reset.
// Latency: coreReset falls 2+1+LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES edges after a steady lock rise; it rises 2+GLITCH_CYCLES edges after a lock loss.
// Backpressure: none; there is no handshake, and every input is sampled each cycle.
//
// Ports:
//   clk        - PLL output clock; the whole block runs on it
//   resetN     - synchronous active-low reset
//   isLocked   - PLL lock, asynchronous to clk (2-flop synchronised)
//   swResetReq - single-cycle software restart request, honoured only in RUN
//   coreReset  - active-high core reset, registered
//   ready      - high while the core runs, registered
//   lossCount  - saturating count of lock-loss events
// Optional macro LOCK_LOSS_COUNTER_EN builds the lock-loss counter;
// without it, lossCount is tied to zero.
module pll_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int RESET_HOLD_CYCLES  = 8,
  parameter int GLITCH_CYCLES      = 4,
  parameter int LOSS_CNT_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      isLocked,
  input  logic                      swResetReq,
  output logic                      coreReset,
  output logic                      ready,
  output logic [LOSS_CNT_WIDTH-1:0] lossCount
);

  localparam int ST_W   = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int HOLD_W = (RESET_HOLD_CYCLES  > 1) ? $clog2(RESET_HOLD_CYCLES)  : 1;
  localparam int DROP_W = (GLITCH_CYCLES      > 1) ? $clog2(GLITCH_CYCLES)      : 1;

  localparam logic [ST_W-1:0]   ST_LAST   = ST_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [DROP_W-1:0] DROP_LAST = DROP_W'(GLITCH_CYCLES - 1);
  localparam logic [ST_W-1:0]   ST_ONE    = ST_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [DROP_W-1:0] DROP_ONE  = DROP_W'(1);

  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    STABILIZE  = 2'd1,
    HOLD_RESET = 2'd2,
    RUN        = 2'd3
  } stateT;

  stateT             state, stateNext;
  logic              lockMeta, lockSync;
  logic [ST_W-1:0]   stCnt, stCntNext;
  logic [HOLD_W-1:0] holdCnt, holdCntNext;
  logic [DROP_W-1:0] dropCnt, dropCntNext;

  // Lock synchroniser. Nothing downstream looks at isLocked directly.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      lockMeta <= 1'b0;
      lockSync <= 1'b0;
    end else begin
      lockMeta <= isLocked;
      lockSync <= lockMeta;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state     <= WAIT_LOCK;
      stCnt     <= '0;
      holdCnt   <= '0;
      dropCnt   <= '0;
      coreReset <= 1'b1;
      ready     <= 1'b0;
    end else begin
      state     <= stateNext;
      stCnt     <= stCntNext;
      holdCnt   <= holdCntNext;
      dropCnt   <= dropCntNext;
      // Outputs are decoded from the next state, so they change on the same
      // edge as the state register does.
      coreReset <= (stateNext != RUN);
      ready     <= (stateNext == RUN);
    end
  end

  // Each counter is only live in its own state. Counters default to zero,
  // so a counter is always clear when its state is entered.
  always_comb begin
    stateNext   = state;
    stCntNext   = '0;
    holdCntNext = '0;
    dropCntNext = '0;
    unique case (state)
      WAIT_LOCK: begin
        if (lockSync) stateNext = STABILIZE;
      end
      STABILIZE: begin
        if (!lockSync)              stateNext = WAIT_LOCK;
        else if (stCnt == ST_LAST)  stateNext = HOLD_RESET;
        else                        stCntNext = stCnt + ST_ONE;
      end
      HOLD_RESET: begin
        // No glitch filtering before RUN: any lock drop restarts the sequence.
        if (!lockSync)                  stateNext   = WAIT_LOCK;
        else if (holdCnt == HOLD_LAST)  stateNext   = RUN;
        else                            holdCntNext = holdCnt + HOLD_ONE;
      end
      RUN: begin
        // When a lock loss completes in the same cycle as a software
        // request, the lock loss wins and is checked first.
        if (!lockSync && (dropCnt == DROP_LAST)) begin
          stateNext = WAIT_LOCK;
        end else begin
          if (!lockSync) dropCntNext = dropCnt + DROP_ONE;
          if (swResetReq) stateNext  = HOLD_RESET;
        end
      end
      default: stateNext = WAIT_LOCK;
    endcase
  end

`ifdef LOCK_LOSS_COUNTER_EN
  logic lossEvent;
  assign lossEvent = (state == RUN) && !lockSync && (dropCnt == DROP_LAST);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      lossCount <= '0;
    end else if (lossEvent && !(&lossCount)) begin
      lossCount <= lossCount + LOSS_CNT_WIDTH'(1);
    end
  end
`else
  assign lossCount = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Purpose: directed self-checking bench for pll_reset_sequencer.
// Latency: inputs are driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_pll_reset_sequencer;

`ifdef LOCK_LOSS_COUNTER_EN
  localparam bit LC_EN = 1'b1;
`else
  localparam bit LC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetN;
  logic       isLocked;
  logic       swResetReq;
  logic       coreReset;
  logic       ready;
  logic [1:0] lossCount;

  int nChecks = 0;
  int nFails  = 0;

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES(16),
    .RESET_HOLD_CYCLES (8),
    .GLITCH_CYCLES     (4),
    .LOSS_CNT_WIDTH    (2)
  ) dut (
    .clk       (clk),
    .resetN    (resetN),
    .isLocked  (isLocked),
    .swResetReq(swResetReq),
    .coreReset (coreReset),
    .ready     (ready),
    .lossCount (lossCount)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic waitEdges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // With the counter disabled, the expected lossCount is always zero;
  // otherwise it saturates at 3 for a 2-bit counter.
  function automatic logic [31:0] expLoss(input int n);
    if (!LC_EN) return 32'd0;
    return (n > 3) ? 32'd3 : 32'(n);
  endfunction

  // coreReset must still be high after n-1 edges and low at edge n.
  task automatic checkRelease(input string tag, input int n);
    waitEdges(n - 1);
    checkEq({tag, "_held"},  32'(coreReset), 32'd1);
    checkEq({tag, "_notrdy"}, 32'(ready),    32'd0);
    waitEdges(1);
    checkEq({tag, "_rel"},   32'(coreReset), 32'd0);
    checkEq({tag, "_rdy"},   32'(ready),     32'd1);
  endtask

  // Lock drop long enough to count: coreReset rises 6 edges after the fall.
  task automatic loseLock(input string tag, input int expN);
    isLocked = 1'b0;
    waitEdges(5);
    checkEq({tag, "_still_run"}, 32'(coreReset), 32'd0);
    waitEdges(1);
    checkEq({tag, "_rst"},  32'(coreReset), 32'd1);
    checkEq({tag, "_rdy"},  32'(ready),     32'd0);
    checkEq({tag, "_cnt"},  32'(lossCount), expLoss(expN));
  endtask

  initial begin
    resetN     = 1'b0;
    isLocked   = 1'b1;
    swResetReq = 1'b0;

    // Power-up reset with lock already high.
    for (int i = 0; i < 5; i++) begin
      waitEdges(1);
      checkEq("rst_coreReset", 32'(coreReset), 32'd1);
      checkEq("rst_ready",     32'(ready),     32'd0);
    end
    checkEq("rst_lossCount", 32'(lossCount), 32'd0);
    resetN = 1'b1;
    checkRelease("pwrup", 27);

    // A 3-cycle drop is filtered.
    isLocked = 1'b0;
    waitEdges(3);
    isLocked = 1'b1;
    for (int i = 0; i < 8; i++) begin
      waitEdges(1);
      checkEq("glitch3_run", 32'(coreReset), 32'd0);
    end
    checkEq("glitch3_cnt", 32'(lossCount), 32'd0);

    // A 4-cycle drop is a loss; relock releases after 27 edges.
    loseLock("loss1", 1);
    isLocked = 1'b1;
    checkRelease("relock1", 27);

    // A software restart in RUN holds reset for exactly 8 cycles.
    swResetReq = 1'b1;
    waitEdges(1);
    swResetReq = 1'b0;
    checkEq("swrst_rst",   32'(coreReset), 32'd1);
    checkEq("swrst_ready", 32'(ready),     32'd0);
    checkRelease("swrst", 8);

    // A software request on the 4th lock-low cycle: lock loss wins.
    isLocked = 1'b0;
    waitEdges(5);
    checkEq("simul_pre", 32'(coreReset), 32'd0);
    swResetReq = 1'b1;
    waitEdges(1);
    swResetReq = 1'b0;
    checkEq("simul_rst", 32'(coreReset), 32'd1);
    checkEq("simul_cnt", 32'(lossCount), expLoss(2));
    isLocked = 1'b1;
    checkRelease("relock2", 27);

    // A software request during STABILIZE is ignored.
    loseLock("loss3", 3);
    isLocked = 1'b1;
    waitEdges(10);
    swResetReq = 1'b1;
    waitEdges(1);
    swResetReq = 1'b0;
    checkEq("stabsw_rst", 32'(coreReset), 32'd1);
    checkRelease("stabsw", 16);

    loseLock("loss4", 4);
    isLocked = 1'b1;
    checkRelease("relock4", 27);

    // Loss 5, then lock chatter: 10 high / 2 low never releases reset.
    loseLock("loss5", 5);
    for (int r = 0; r < 4; r++) begin
      isLocked = 1'b1;
      for (int i = 0; i < 10; i++) begin
        waitEdges(1);
        checkEq("chatter_hi", 32'(coreReset), 32'd1);
      end
      isLocked = 1'b0;
      for (int i = 0; i < 2; i++) begin
        waitEdges(1);
        checkEq("chatter_lo", 32'(coreReset), 32'd1);
      end
    end
    isLocked = 1'b1;
    checkRelease("chatter", 27);

    // Reset from RUN clears everything.
    resetN = 1'b0;
    waitEdges(1);
    checkEq("rst2_coreReset", 32'(coreReset), 32'd1);
    checkEq("rst2_ready",     32'(ready),     32'd0);
    checkEq("rst2_lossCount", 32'(lossCount), 32'd0);
    resetN = 1'b1;
    waitEdges(2);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
